instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the opcode decoder. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Presents each fetched instruction with its PC to decode over a valid/ready handshake; decode routes `instr_o[31:26]` to the control decoder. Accepts a single redirect (taken branch, jump, jr) from execute and discards wrong-path fetches.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack reads, valid/ready hand-off to decode, redirect with wrong-path drop.
// Optional macro FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag on misalign_o.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misalign_o,
  output logic [1:0]  dbg_state_o  // 0 = FETCH, 1 = HOLD, 2 = DROP
);

  // Handshakes: a memory read completes in any cycle where imem_req_o and
  // imem_ack_i are both high; decode takes the instruction in any cycle where
  // instr_valid_o and instr_ready_i are both high. Neither valid line waits on
  // its ready, and redirect_i overrides every other event in the same cycle.

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        w_capture;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = imem_ack_i ? S_FETCH : S_DROP;
        end else if (imem_ack_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // A redirect wins over PC+4 even when decode consumes this cycle.
        if (redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_FETCH;
        end else if (instr_ready_i) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = imem_ack_i ? S_FETCH : S_DROP;
        end else if (imem_ack_i) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= 32'd0;
      r_pc_out <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= (w_state_nxt == S_HOLD);
      if (w_capture) begin
        r_instr  <= imem_data_i;
        r_pc_out <= r_pc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_misalign <= 1'b0;
    end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_o = r_misalign;
`else
  assign misalign_o = 1'b0;
`endif

  // The request is gated by reset so an in-flight read is abandoned at once.
  assign imem_req_o    = rst_i && ((r_state == S_FETCH) || (r_state == S_DROP));
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_out;
  assign pc_plus4_o    = r_pc_out + 32'd4;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a PC-stream reference model.
// Define FETCH_ALIGN_CHECK_EN for both RTL and bench to cover the misalign flag.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'd0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        misalign_o;
  logic [1:0]  dbg_state_o;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .misalign_o(misalign_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset: posedge at 5, 15, ...; inputs change on the negedge.
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          deliveries = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic        m_mis = 1'b0;
  logic        prev_rst = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_tgt = 32'd0;
  int          lat_cur = 0;
  logic        rand_lat = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] req_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3008) return 32'h8C22_0004;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a * 32'd3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: latches the address when a request starts, acks after lat_cur waits.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (imem_req_o === 1'b1) begin
        if (wait_cnt == 0) begin
          req_addr = imem_addr_o;
          if (rand_lat) lat_cur = $urandom_range(0, 3);
        end
        if (wait_cnt >= lat_cur) begin
          imem_ack_i  = 1'b1;
          imem_data_i = mem_word(req_addr);
          wait_cnt    = 0;
        end else begin
          imem_ack_i  = 1'b0;
          imem_data_i = $urandom();
          wait_cnt++;
        end
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom();
        wait_cnt    = 0;
      end
    end
  end

  // Driver: one call = one clock cycle. exp_q holds the PCs decode should see,
  // front first; a redirect or reset throws away everything not yet consumed.
  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic hs;
    @(negedge clk);
    if (!prev_rst) m_mis = 1'b0;
    else if (prev_redir && (prev_tgt[1:0] != 2'b00)) m_mis = ALIGN_EN;
    rst_i         = rst;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    hs = rst && rdy && (instr_valid_o === 1'b1);
    if (!rst) begin
      exp_q = {RST_PC};
    end else if (redir) begin
      if (hs && exp_q.size() > 0) exp_q = {exp_q[0], tgt & 32'hFFFF_FFFC};
      else exp_q = {tgt & 32'hFFFF_FFFC};
    end else if (hs && exp_q.size() > 0) begin
      exp_q.push_back(exp_q[0] + 32'd4);
    end
    prev_rst   = rst;
    prev_redir = rst && redir;
    prev_tgt   = tgt;
    #2;
  endtask

  // Monitor / scoreboard: just before each rising edge.
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
        if (rst_i && imem_req_o && !redirect_i) begin
          if (exp_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
          else chk("req_addr", imem_addr_o, exp_q[0]);
        end
        if (rst_i && instr_valid_o && instr_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("deliver_unexpected", pc_o, 32'hDEAD_DEAD);
          end else begin
            exp_pc = exp_q.pop_front();
            deliveries++;
            chk("deliver_pc", pc_o, exp_pc);
            chk("deliver_instr", instr_o, mem_word(exp_pc));
            chk("deliver_pc4", pc_plus4_o, exp_pc + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    // Reset and zero-wait fetch
    lat_cur  = 0;
    rand_lat = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state_o}, 32'd0);
    mon_en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step(1, 1, 0, 0);
      chk("zw_req", {31'd0, imem_req_o}, {31'd0, c[0]});
      if (c[0]) chk("zw_addr", imem_addr_o, RST_PC + 32'(2 * (c - 1)));
      if (c == 2) begin
        chk("zw_pc", pc_o, 32'h0000_3000);
        chk("zw_pc4", pc_plus4_o, 32'h0000_3004);
      end
    end
    // Back-pressure with 0x8C22_0004 presented
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0);
      chk("bp_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("bp_pc", pc_o, 32'h0000_3008);
      chk("bp_instr", instr_o, 32'h8C22_0004);
      chk("bp_req", {31'd0, imem_req_o}, 32'd0);
    end
    step(1, 1, 0, 0);
    chk("bp_req_hs", {31'd0, imem_req_o}, 32'd0);
    // Redirect while a slow read is outstanding
    lat_cur = 3;
    step(1, 0, 1, 32'h0000_0040);
    chk("rd_req", {31'd0, imem_req_o}, 32'd1);
    chk("rd_addr0", imem_addr_o, 32'h0000_300C);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      chk("rd_state_drop", {30'd0, dbg_state_o}, 32'd2);
      chk("rd_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rd_addr", imem_addr_o, 32'h0000_0040);
    end
    lat_cur = 0;
    step(1, 0, 0, 0);
    chk("rd_state_fetch", {30'd0, dbg_state_o}, 32'd0);
    chk("rd_refetch", imem_addr_o, 32'h0000_0040);
    // Redirect with simultaneous handshake
    step(1, 1, 1, 32'h0000_0100);
    chk("rh_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("rh_pc", pc_o, 32'h0000_0040);
    step(1, 0, 0, 0);
    chk("rh_addr", imem_addr_o, 32'h0000_0100);
    chk("rh_valid_drop", {31'd0, instr_valid_o}, 32'd0);
    // Wrap-around
    step(1, 0, 1, 32'hFFFF_FFFC);
    chk("rh_pc2", pc_o, 32'h0000_0100);
    step(1, 0, 0, 0);
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_o, 32'h0000_0000);
    // Misaligned redirect coinciding with an ack
    step(1, 0, 1, 32'h0000_0042);
    chk("wrap_addr", imem_addr_o, 32'h0000_0000);
    step(1, 0, 0, 0);
    chk("mis_addr", imem_addr_o, 32'h0000_0040);
    chk("mis_state", {30'd0, dbg_state_o}, 32'd0);
    chk("mis_flag", {31'd0, misalign_o}, {31'd0, ALIGN_EN});
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
    chk("mis_sticky", {31'd0, misalign_o}, {31'd0, ALIGN_EN});
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("mis_rst_flag", {31'd0, misalign_o}, 32'd0);
    chk("mis_rst_req", {31'd0, imem_req_o}, 32'd0);
    step(1, 0, 0, 0);
    chk("mis_rst_addr", imem_addr_o, RST_PC);
    chk("mis_rst_reqhi", {31'd0, imem_req_o}, 32'd1);
    // Randomized traffic
    rand_lat = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt[31:4] = 28'hFFF_FFFF;
      if ($urandom_range(0, 499) == 0) step(0, 0, 0, 0);
      else step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, tgt);
    end
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0);
    chk("deliveries_min", (deliveries > 400) ? 32'd1 : 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
